// File: rtl/lsu_dcache_arbiter_if.sv
// ---------------------------------------------------------------------------
// lsu_dcache_arbiter_if
// Bundle of every handshake and bus signal around the dcache arbiter:
//   - three request channels (ptw read, ld read, st write) with ready and
//     read-response valid strobes,
//   - the single downstream dcache request port and its in-order response,
//   - the shared response data bus back to the ld/ptw consumers.
// Signal suffixes (_i/_o) are named from the arbiter's point of view.
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters + dcache)
// ---------------------------------------------------------------------------
interface lsu_dcache_arbiter_if #(
    parameter int XLEN = 64
);
    // page-table walker channel
    logic            ptw_req_valid_i;
    logic            ptw_req_ready_o;
    logic [XLEN-1:0] ptw_addr_i;
    logic            ptw_rvalid_o;
    // load channel
    logic            ld_req_valid_i;
    logic            ld_req_ready_o;
    logic [XLEN-1:0] ld_addr_i;
    logic [1:0]      ld_size_i;
    logic            ld_rvalid_o;
    // committed store channel
    logic            st_req_valid_i;
    logic            st_req_ready_o;
    logic [XLEN-1:0] st_addr_i;
    logic [1:0]      st_size_i;
    logic [XLEN-1:0] st_wdata_i;
    logic [7:0]      st_wmask_i;
    // downstream dcache port
    logic            mem_req_valid_o;
    logic            mem_req_ready_i;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [1:0]      mem_size_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [7:0]      mem_wmask_o;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;
    // shared response data
    logic [XLEN-1:0] rdata_o;

    modport slave (
        input  ptw_req_valid_i, ptw_addr_i,
        input  ld_req_valid_i, ld_addr_i, ld_size_i,
        input  st_req_valid_i, st_addr_i, st_size_i, st_wdata_i, st_wmask_i,
        input  mem_req_ready_i, mem_rvalid_i, mem_rdata_i,
        output ptw_req_ready_o, ptw_rvalid_o,
        output ld_req_ready_o, ld_rvalid_o,
        output st_req_ready_o,
        output mem_req_valid_o, mem_we_o, mem_addr_o, mem_size_o,
        output mem_wdata_o, mem_wmask_o,
        output rdata_o
    );

    modport master (
        output ptw_req_valid_i, ptw_addr_i,
        output ld_req_valid_i, ld_addr_i, ld_size_i,
        output st_req_valid_i, st_addr_i, st_size_i, st_wdata_i, st_wmask_i,
        output mem_req_ready_i, mem_rvalid_i, mem_rdata_i,
        input  ptw_req_ready_o, ptw_rvalid_o,
        input  ld_req_ready_o, ld_rvalid_o,
        input  st_req_ready_o,
        input  mem_req_valid_o, mem_we_o, mem_addr_o, mem_size_o,
        input  mem_wdata_o, mem_wmask_o,
        input  rdata_o
    );
endinterface

// File: rtl/lsu_dcache_arbiter.sv
// ---------------------------------------------------------------------------
// lsu_dcache_arbiter
// Shares one dcache request port between the page-table walker (read), the
// load path (read) and the committed store drain (write).
//   - Fixed priority ptw > ld > st, except that a store blocked for
//     STARVE_LIMIT consecutive cycles jumps to the top.
//   - Grant is combinational; mem_* mirror the granted requester.
//   - Outstanding reads are tracked in an in-order tag FIFO holding
//     {owner, kill}; each in-order response pops the head and is routed to
//     its owner. Flushed loads are dropped silently.
// Ports:
//   clk     - clock
//   rstn    - synchronous active-low reset
//   flush_i - kill in-flight/pending load responses, block new loads
//   bus     - all request/response/dcache signals (slave modport)
//   err_o   - sticky error: response arrived with no outstanding read
// XLEN must match the XLEN of the connected interface instance.
// MAX_OUTSTANDING must be a power of two so pointers wrap naturally.
// ---------------------------------------------------------------------------
module lsu_dcache_arbiter #(
    parameter int XLEN            = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush_i,
    lsu_dcache_arbiter_if.slave    bus,
    output logic                   err_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

    // tag FIFO storage: owner 1 = ptw, 0 = ld
    logic [MAX_OUTSTANDING-1:0] r_owner;
    logic [MAX_OUTSTANDING-1:0] r_kill;
    logic [PTR_W-1:0]           r_wptr;
    logic [PTR_W-1:0]           r_rptr;
    logic [CNT_W-1:0]           r_count;
    logic [SC_W-1:0]            r_starve_cnt;
    logic                       r_err;

    logic w_full;
    logic w_empty;
    logic w_ptw_elig;
    logic w_ld_elig;
    logic w_starved;
    logic w_gnt_ptw;
    logic w_gnt_ld;
    logic w_gnt_st;
    logic w_ptw_hs;
    logic w_ld_hs;
    logic w_st_hs;
    logic w_push;
    logic w_pop;
    logic w_head_owner;
    logic w_head_kill;

    // Full is judged on the registered count only: a same-cycle pop does not
    // open a slot, which keeps ready off the response path.
    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == {CNT_W{1'b0}});
    assign w_ptw_elig = bus.ptw_req_valid_i & ~w_full;
    assign w_ld_elig  = bus.ld_req_valid_i & ~w_full & ~flush_i;
    assign w_starved  = bus.st_req_valid_i & (r_starve_cnt == STARVE_MAX);

    // Grant selection: starved store, then ptw, ld, st; nothing in reset.
    always_comb begin
        w_gnt_ptw = 1'b0;
        w_gnt_ld  = 1'b0;
        w_gnt_st  = 1'b0;
        if (!rstn) begin
            w_gnt_st = 1'b0;
        end else if (w_starved) begin
            w_gnt_st = 1'b1;
        end else if (w_ptw_elig) begin
            w_gnt_ptw = 1'b1;
        end else if (w_ld_elig) begin
            w_gnt_ld = 1'b1;
        end else if (bus.st_req_valid_i) begin
            w_gnt_st = 1'b1;
        end else begin
            w_gnt_st = 1'b0;
        end
    end

    assign w_ptw_hs = w_gnt_ptw & bus.mem_req_ready_i;
    assign w_ld_hs  = w_gnt_ld  & bus.mem_req_ready_i;
    assign w_st_hs  = w_gnt_st  & bus.mem_req_ready_i;
    assign w_push   = w_ptw_hs | w_ld_hs;

    assign bus.ptw_req_ready_o = w_ptw_hs;
    assign bus.ld_req_ready_o  = w_ld_hs;
    assign bus.st_req_ready_o  = w_st_hs;
    assign bus.mem_req_valid_o = w_gnt_ptw | w_gnt_ld | w_gnt_st;
    assign bus.mem_we_o        = w_gnt_st;

    // Downstream request mux; ptw walks always fetch a full doubleword.
    always_comb begin
        bus.mem_addr_o  = {XLEN{1'b0}};
        bus.mem_size_o  = 2'b00;
        bus.mem_wdata_o = {XLEN{1'b0}};
        bus.mem_wmask_o = 8'h00;
        if (w_gnt_st) begin
            bus.mem_addr_o  = bus.st_addr_i;
            bus.mem_size_o  = bus.st_size_i;
            bus.mem_wdata_o = bus.st_wdata_i;
            bus.mem_wmask_o = bus.st_wmask_i;
        end else if (w_gnt_ptw) begin
            bus.mem_addr_o  = bus.ptw_addr_i;
            bus.mem_size_o  = 2'b11;
        end else if (w_gnt_ld) begin
            bus.mem_addr_o  = bus.ld_addr_i;
            bus.mem_size_o  = bus.ld_size_i;
        end else begin
            bus.mem_addr_o  = {XLEN{1'b0}};
        end
    end

    // Response routing: a response with no tag is an error, not a pop.
    assign w_pop        = rstn & bus.mem_rvalid_i & ~w_empty;
    assign w_head_owner = r_owner[r_rptr];
    assign w_head_kill  = r_kill[r_rptr];

    assign bus.ptw_rvalid_o = w_pop & w_head_owner;
    assign bus.ld_rvalid_o  = w_pop & ~w_head_owner & ~w_head_kill & ~flush_i;
    assign bus.rdata_o      = bus.mem_rdata_i;
    assign err_o            = r_err;

    // Tag FIFO, starvation counter and sticky error state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_owner      <= {MAX_OUTSTANDING{1'b0}};
            r_kill       <= {MAX_OUTSTANDING{1'b0}};
            r_wptr       <= {PTR_W{1'b0}};
            r_rptr       <= {PTR_W{1'b0}};
            r_count      <= {CNT_W{1'b0}};
            r_starve_cnt <= {SC_W{1'b0}};
            r_err        <= 1'b0;
        end else begin
            // Flush marks every ld tag; stale slots are harmless since a
            // push rewrites both fields. The push below takes precedence.
            if (flush_i) begin
                for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                    if (!r_owner[i]) begin
                        r_kill[i] <= 1'b1;
                    end else begin
                        r_kill[i] <= r_kill[i];
                    end
                end
            end else begin
                r_kill <= r_kill;
            end

            if (w_push) begin
                r_owner[r_wptr] <= w_gnt_ptw;
                r_kill[r_wptr]  <= flush_i;
                r_wptr          <= r_wptr + 1'b1;
            end else begin
                r_wptr <= r_wptr;
            end

            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end else begin
                r_rptr <= r_rptr;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (bus.mem_rvalid_i && w_empty) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end

            if (!bus.st_req_valid_i || w_st_hs) begin
                r_starve_cnt <= {SC_W{1'b0}};
            end else if (r_starve_cnt != STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end else begin
                r_starve_cnt <= r_starve_cnt;
            end
        end
    end

endmodule

// File: tb/tb_lsu_dcache_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lsu_dcache_arbiter
// Directed bench with a response scoreboard: every accepted read pushes
// {owner, kill, data}; the bench, acting as the dcache, answers in order by
// popping the queue and checks routing and data on the response cycle.
// ---------------------------------------------------------------------------
module tb_lsu_dcache_arbiter;

    localparam int XLEN = 64;

    typedef struct packed {
        logic            owner;
        logic            kill;
        logic [XLEN-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic flush_i = 1'b0;
    logic err_o;

    int n_total = 0;
    int n_bad   = 0;

    exp_t            exp_q[$];
    logic [XLEN-1:0] ptw_rsp;
    logic [XLEN-1:0] ld_rsp;

    lsu_dcache_arbiter_if #(.XLEN(XLEN)) bif ();

    lsu_dcache_arbiter #(
        .XLEN            (XLEN),
        .MAX_OUTSTANDING (4),
        .STARVE_LIMIT    (8)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .flush_i (flush_i),
        .bus     (bif.slave),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bif.ptw_req_valid_i = 1'b0;
        bif.ptw_addr_i      = '0;
        bif.ld_req_valid_i  = 1'b0;
        bif.ld_addr_i       = '0;
        bif.ld_size_i       = 2'b11;
        bif.st_req_valid_i  = 1'b0;
        bif.st_addr_i       = '0;
        bif.st_size_i       = 2'b11;
        bif.st_wdata_i      = '0;
        bif.st_wmask_i      = 8'h00;
        bif.mem_req_ready_i = 1'b1;
        bif.mem_rvalid_i    = 1'b0;
        bif.mem_rdata_i     = '0;
    endtask

    // Record what the coming edge does to the scoreboard, then advance.
    task automatic tick();
        #1;
        if (rstn) begin
            if (flush_i) begin
                foreach (exp_q[i]) if (!exp_q[i].owner) exp_q[i].kill = 1'b1;
            end
            if (bif.ptw_req_valid_i && bif.ptw_req_ready_o)
                exp_q.push_back('{owner: 1'b1, kill: 1'b0, data: ptw_rsp});
            if (bif.ld_req_valid_i && bif.ld_req_ready_o)
                exp_q.push_back('{owner: 1'b0, kill: flush_i, data: ld_rsp});
        end
        @(posedge clk);
        #1;
        bif.mem_rvalid_i = 1'b0;
    endtask

    // Return the oldest outstanding read and check where it is routed.
    task automatic respond();
        exp_t e;
        chk("rsp_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            bif.mem_rvalid_i = 1'b1;
            bif.mem_rdata_i  = e.data;
            #1;
            chk("rsp_ptw_rvalid", bif.ptw_rvalid_o, e.owner);
            chk("rsp_ld_rvalid", bif.ld_rvalid_o, !e.owner && !e.kill && !flush_i);
            chk("rsp_rdata", bif.rdata_o, e.data);
        end
    endtask

    initial begin
        idle_inputs();
        // reset with everything asserted: no grants, no responses
        bif.ptw_req_valid_i = 1'b1;
        bif.ld_req_valid_i  = 1'b1;
        bif.st_req_valid_i  = 1'b1;
        bif.mem_rvalid_i    = 1'b1;
        #2;
        chk("rst_ptw_rdy", bif.ptw_req_ready_o, 1'b0);
        chk("rst_ld_rdy", bif.ld_req_ready_o, 1'b0);
        chk("rst_st_rdy", bif.st_req_ready_o, 1'b0);
        chk("rst_mem_valid", bif.mem_req_valid_o, 1'b0);
        chk("rst_ld_rvalid", bif.ld_rvalid_o, 1'b0);
        chk("rst_ptw_rvalid", bif.ptw_rvalid_o, 1'b0);
        tick();
        bif.mem_rvalid_i = 1'b1;
        tick();
        idle_inputs();
        rstn = 1'b1;
        #1;
        chk("rst_err", err_o, 1'b0);
        chk("rst_count", dut.r_count, 0);

        // ld beats st for three cycles, store starvation accumulates
        bif.ld_req_valid_i = 1'b1;
        bif.st_req_valid_i = 1'b1;
        bif.st_addr_i      = 64'h3000;
        for (int i = 0; i < 3; i++) begin
            bif.ld_addr_i = 64'h100 + 64'(i * 8);
            ld_rsp        = 64'h1000 + 64'(i);
            #1;
            chk("t1_ld_rdy", bif.ld_req_ready_o, 1'b1);
            chk("t1_st_rdy", bif.st_req_ready_o, 1'b0);
            chk("t1_mem_addr", bif.mem_addr_o, 64'h100 + 64'(i * 8));
            tick();
        end
        chk("t1_starve_cnt", dut.r_starve_cnt, 3);
        bif.ld_req_valid_i = 1'b0;
        bif.st_req_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            respond();
            tick();
        end

        // starvation override on the ninth cycle, then counter restarts
        bif.ld_req_valid_i = 1'b1;
        bif.ld_size_i      = 2'b10;
        bif.st_req_valid_i = 1'b1;
        bif.st_addr_i      = 64'h3008;
        bif.st_size_i      = 2'b01;
        bif.st_wdata_i     = 64'hDEAD_BEEF_0123_4567;
        bif.st_wmask_i     = 8'h0F;
        for (int c = 1; c <= 10; c++) begin
            bif.ld_addr_i = 64'h4000 + 64'(c * 8);
            ld_rsp        = 64'h5000 + 64'(c);
            if (exp_q.size() != 0) respond();
            else #1;
            if (c == 9) begin
                chk("t2_st_rdy", bif.st_req_ready_o, 1'b1);
                chk("t2_ld_blocked", bif.ld_req_ready_o, 1'b0);
                chk("t2_we", bif.mem_we_o, 1'b1);
                chk("t2_st_addr", bif.mem_addr_o, 64'h3008);
                chk("t2_st_size", bif.mem_size_o, 2'b01);
                chk("t2_wdata", bif.mem_wdata_o, 64'hDEAD_BEEF_0123_4567);
                chk("t2_wmask", bif.mem_wmask_o, 8'h0F);
            end else begin
                chk("t2_ld_rdy", bif.ld_req_ready_o, 1'b1);
                chk("t2_st_wait", bif.st_req_ready_o, 1'b0);
                chk("t2_ld_size", bif.mem_size_o, 2'b10);
            end
            tick();
        end
        bif.ld_req_valid_i = 1'b0;
        bif.st_req_valid_i = 1'b0;
        respond();
        tick();

        // ptw outranks ld; responses come back in issue order
        bif.ptw_req_valid_i = 1'b1;
        bif.ptw_addr_i      = 64'h1000;
        ptw_rsp             = 64'hAA;
        bif.ld_req_valid_i  = 1'b1;
        bif.ld_addr_i       = 64'h2000;
        ld_rsp              = 64'hBB;
        #1;
        chk("t3_ptw_rdy", bif.ptw_req_ready_o, 1'b1);
        chk("t3_ld_wait", bif.ld_req_ready_o, 1'b0);
        chk("t3_ptw_addr", bif.mem_addr_o, 64'h1000);
        chk("t3_ptw_size", bif.mem_size_o, 2'b11);
        tick();
        bif.ptw_req_valid_i = 1'b0;
        #1;
        chk("t3_ld_rdy", bif.ld_req_ready_o, 1'b1);
        chk("t3_ld_addr", bif.mem_addr_o, 64'h2000);
        tick();
        bif.ld_req_valid_i = 1'b0;
        respond();
        tick();
        respond();
        tick();

        // fill the FIFO: loads blocked, store still served
        bif.ld_req_valid_i = 1'b1;
        bif.st_req_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bif.ld_addr_i = 64'h6000 + 64'(i * 8);
            ld_rsp        = 64'h7000 + 64'(i);
            #1;
            chk("t4_fill_ld_rdy", bif.ld_req_ready_o, 1'b1);
            tick();
        end
        bif.ld_addr_i = 64'h6020;
        ld_rsp        = 64'h7004;
        #1;
        chk("t4_full_ld_rdy", bif.ld_req_ready_o, 1'b0);
        chk("t4_full_st_rdy", bif.st_req_ready_o, 1'b1);
        chk("t4_full_we", bif.mem_we_o, 1'b1);
        tick();
        bif.st_req_valid_i = 1'b0;
        #1;
        chk("t4_full_no_req", bif.mem_req_valid_o, 1'b0);
        tick();
        respond();
        chk("t4_pop_cycle_ld_rdy", bif.ld_req_ready_o, 1'b0);
        tick();
        #1;
        chk("t4_after_pop_ld_rdy", bif.ld_req_ready_o, 1'b1);
        tick();
        bif.ld_req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            respond();
            tick();
        end

        // flush with two loads and a ptw in flight
        bif.ld_req_valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bif.ld_addr_i = 64'h8000 + 64'(i * 8);
            ld_rsp        = 64'h8800 + 64'(i);
            tick();
        end
        bif.ld_req_valid_i  = 1'b0;
        bif.ptw_req_valid_i = 1'b1;
        bif.ptw_addr_i      = 64'h9000;
        ptw_rsp             = 64'h9900;
        tick();
        bif.ptw_req_valid_i = 1'b0;
        bif.ld_req_valid_i  = 1'b1;
        flush_i             = 1'b1;
        #1;
        chk("t5_flush_ld_rdy", bif.ld_req_ready_o, 1'b0);
        chk("t5_flush_no_req", bif.mem_req_valid_o, 1'b0);
        tick();
        flush_i            = 1'b0;
        bif.ld_req_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            respond();
            tick();
        end
        // response arriving while flush is high is dropped too
        bif.ld_req_valid_i = 1'b1;
        bif.ld_addr_i      = 64'hA000;
        ld_rsp             = 64'hAA00;
        tick();
        bif.ld_req_valid_i = 1'b0;
        flush_i            = 1'b1;
        respond();
        tick();
        flush_i = 1'b0;
        #1;
        chk("t5_fifo_empty", dut.r_count, 0);
        chk("t5_no_err", err_o, 1'b0);

        // stray response sets a sticky error
        bif.mem_rvalid_i = 1'b1;
        bif.mem_rdata_i  = 64'h55;
        #1;
        chk("t6_stray_ld_rvalid", bif.ld_rvalid_o, 1'b0);
        chk("t6_stray_ptw_rvalid", bif.ptw_rvalid_o, 1'b0);
        tick();
        chk("t6_err_set", err_o, 1'b1);
        chk("t6_count_unchanged", dut.r_count, 0);
        tick();
        tick();
        chk("t6_err_held", err_o, 1'b1);
        // reset mid-operation drops the outstanding tag
        bif.ld_req_valid_i = 1'b1;
        bif.ld_addr_i      = 64'hB000;
        ld_rsp             = 64'hBB00;
        tick();
        bif.ld_req_valid_i = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        exp_q.delete();
        chk("t6_err_cleared", err_o, 1'b0);
        chk("t6_count_cleared", dut.r_count, 0);
        bif.mem_rvalid_i = 1'b1;
        #1;
        chk("t6_late_ld_rvalid", bif.ld_rvalid_o, 1'b0);
        tick();
        chk("t6_late_err", err_o, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_dcache_arbiter.md
Name: lsu_dcache_arbiter

Overview:
- Shares the single dcache request port between three requesters: the page-table walker (read), the LSU load path (read), and the committed store-queue drain (write).
- Applies fixed priority ptw > ld > st, with an anti-starvation override for stores.
- Tracks outstanding reads in an in-order tag FIFO and routes each response to its owner.
- Supports a pipeline flush that silently drops in-flight load responses.

Parameters:
- XLEN, 64, data/address width.
- MAX_OUTSTANDING, 4, maximum reads in flight (tag FIFO depth, power of two).
- STARVE_LIMIT, 8, consecutive blocked cycles after which a pending store gets top priority.

Ports:
- clk  input  1  clock.
- rstn  input  1  synchronous active-low reset.
- flush_i  input  1  kill all in-flight and pending load responses.
- ptw_req_valid_i  input  1  PTW read request.
- ptw_req_ready_o  output  1  PTW request accepted.
- ptw_addr_i  input  XLEN  PTW physical address.
- ptw_rvalid_o  output  1  PTW response valid.
- ld_req_valid_i  input  1  load read request.
- ld_req_ready_o  output  1  load request accepted.
- ld_addr_i  input  XLEN  load physical address.
- ld_size_i  input  2  load size (B/H/W/D).
- ld_rvalid_o  output  1  load response valid.
- st_req_valid_i  input  1  committed store request.
- st_req_ready_o  output  1  store accepted.
- st_addr_i  input  XLEN  store address.
- st_size_i  input  2  store size.
- st_wdata_i  input  XLEN  store data, pre-aligned.
- st_wmask_i  input  8  byte mask.
- mem_req_valid_o  output  1  downstream request valid.
- mem_req_ready_i  input  1  downstream ready.
- mem_we_o  output  1  1 = write.
- mem_addr_o  output  XLEN  downstream address.
- mem_size_o  output  2  downstream size.
- mem_wdata_o  output  XLEN  downstream write data.
- mem_wmask_o  output  8  downstream byte mask.
- mem_rvalid_i  input  1  read response valid (in order, no backpressure).
- mem_rdata_i  input  XLEN  read response data.
- rdata_o  output  XLEN  response data, shared by the ld and ptw response channels.
- err_o  output  1  sticky protocol error.

Behaviour:
- Reset (rstn low at posedge clk):
  - Tag FIFO pointers, count, starvation counter and err_o are cleared.
  - While rstn is low, all *_ready_o, mem_req_valid_o and *_rvalid_o are forced to 0.
- Requests are not registered: grant is combinational from valids and state, and mem_* mirror the granted requester.
  - A handshake on one requester occurs iff its valid, its grant, and mem_req_ready_i are all high.
- Read eligibility: a read (ptw or ld) is eligible only when the tag FIFO is not full.
  - The FIFO counts as full at MAX_OUTSTANDING entries, regardless of a same-cycle pop.
- Priority:
  - Starved store (starve_cnt == STARVE_LIMIT and st valid): st wins.
  - Otherwise: eligible ptw, then eligible ld, then st.
  - Stores need no FIFO space.
- Starvation counter, saturating:
  - Cleared on a st handshake or when st_req_valid_i is low.
  - Increments each cycle st_req_valid_i is high without a handshake.
- Ready rules:
  - Non-granted requesters see ready = 0.
  - The granted requester sees ready = mem_req_ready_i.
  - mem_req_valid_o = 1 iff some requester is granted.
- Tag FIFO:
  - Each read handshake pushes {owner (0 = ld, 1 = ptw), kill = flush_i}.
  - Each mem_rvalid_i pops the head entry.
  - Push and pop in the same cycle are both performed and the count is unchanged.
- Response routing, on pop:
  - ptw_rvalid_o = owner == ptw.
  - ld_rvalid_o = owner == ld && !kill && !flush_i.
  - rdata_o = mem_rdata_i, combinational and zero latency.
- Flush:
  - flush_i sets the kill bit of every ld entry currently in the FIFO, on the next edge.
  - PTW entries are never killed.
  - ld_req_valid_i is ignored (not granted) while flush_i is high.
- Errors: mem_rvalid_i with an empty FIFO sets err_o sticky until reset; the FIFO is unchanged.
- Pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-operation discards all outstanding tags; later stray responses set err_o.

Test Plan:
- ld and st both valid for 3 cycles, mem_req_ready_i = 1 -> 3 ld handshakes, st ready = 0, starve_cnt = 3.
- st valid, ld valid every cycle, STARVE_LIMIT = 8 -> st granted on cycle 9 (count reached 8), counter then clears.
- ptw and ld valid together, addr 0x1000 / 0x2000 -> ptw granted first. Responses 0xAA, 0xBB -> ptw_rvalid_o with 0xAA, then ld_rvalid_o with 0xBB.
- Issue 4 loads with no responses (MAX_OUTSTANDING = 4) -> ld_req_ready_o = 0 and st still granted; one mem_rvalid_i -> the 5th load accepted on the next cycle.
- 2 loads in flight, flush_i pulse, then 2 responses -> ld_rvalid_o stays 0 and the FIFO is empty afterwards.
- mem_rvalid_i with the FIFO empty after reset -> err_o = 1 and held; rstn low for one cycle -> err_o = 0.
